// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt/exception controller: cause encoding,
// exception codes, controller states and SR-bus register offsets.
package irq_ctrl_pkg;

  // Exception codes placed in the low nibble of the cause register
  localparam logic [3:0] IRQC_EXC_SYS  = 4'd0;
  localparam logic [3:0] IRQC_EXC_TRAP = 4'd1;
  localparam logic [3:0] IRQC_EXC_MEM  = 4'd2;

  // Register offsets from the SR-bus base address
  localparam logic [1:0] IRQC_SR_PEND  = 2'd0;
  localparam logic [1:0] IRQC_SR_MASK  = 2'd1;
  localparam logic [1:0] IRQC_SR_CAUSE = 2'd2;
  localparam logic [1:0] IRQC_SR_STATE = 2'd3;

  // Controller state; SERVICE means a handler is running
  typedef enum logic {
    IRQC_ST_IDLE    = 1'b0,
    IRQC_ST_SERVICE = 1'b1
  } irqc_state_t;

  // The exception flag is the MSB of the cause register for any data width
  function automatic int irqc_cause_exc_bit(input int rw);
    return rw - 1;
  endfunction

endpackage

// File: rtl/irq_ctrl_sync.sv
// Per-line synchroniser for asynchronous irq inputs followed by a rising-edge
// detector on the synchronised value. STAGES=0 passes the lines straight through.
module irq_sync #(
  parameter int N      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         srst,
  input  logic [N-1:0] irq,
  output logic [N-1:0] s,
  output logic [N-1:0] rise
);

  logic [N-1:0] prev_reg;

  generate
    if (STAGES == 0) begin : g_nosync
      assign s = irq;
    end else begin : g_sync
      logic [N-1:0] stage_reg [STAGES];

      // Shift the raw lines through STAGES flops
      always_ff @(posedge clk) begin
        if (srst) begin
          for (int i = 0; i < STAGES; i++) stage_reg[i] <= '0;
        end else begin
          stage_reg[0] <= irq;
          for (int i = 1; i < STAGES; i++) stage_reg[i] <= stage_reg[i-1];
        end
      end

      assign s = stage_reg[STAGES-1];
    end
  endgenerate

  // Remember the previous synchronised value for edge detection
  always_ff @(posedge clk) begin
    if (srst) prev_reg <= '0;
    else      prev_reg <= s;
  end

  assign rise = s & ~prev_reg;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt/exception controller for the execute stage. Latches external lines
// as pending, masks and prioritises them against the core exceptions, raises
// one request, and exposes pend/mask/cause/state on the SR bus.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int              RW          = 16,
  parameter int              N_IRQ       = 8,
  parameter int              SYNC_STAGES = 2,
  parameter logic [N_IRQ-1:0] EDGE_MASK  = '0,
  parameter logic [RW-1:0]   SR_BASE     = 'h200
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_IRQ-1:0] i_irq,
  input  logic             i_irq_en,
  input  logic             i_exc_sys,
  input  logic             i_exc_trap,
  input  logic             i_exc_mem,
  input  logic             i_take,
  input  logic             i_irt,
  output logic             o_irq,
  output logic [RW-1:0]    o_cause,
  input  logic [RW-1:0]    sr_bus_addr,
  input  logic [RW-1:0]    sr_bus_data_i,
  input  logic             sr_bus_we,
  output logic [RW-1:0]    sr_bus_data_o
);

  localparam int IW            = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
  localparam int CAUSE_EXC_BIT = irqc_cause_exc_bit(RW);

  irqc_state_t      state_reg, state_next;
  logic [N_IRQ-1:0] irq_s, irq_rise, pend_reg, pend_next, mask_reg, masked;
  logic [RW-1:0]    cause_reg, cause_next, sr_off;
  logic             sr_hit, wr_pend, wr_mask, wr_state;
  logic             exc_any, line_req, take_line;
  logic [3:0]       exc_code;
  logic [IW-1:0]    win_idx;
  logic             unused_ok;

  irq_sync #(.N(N_IRQ), .STAGES(SYNC_STAGES)) u_sync (
    .clk  (i_clk),
    .srst (i_rst),
    .irq  (i_irq),
    .s    (irq_s),
    .rise (irq_rise)
  );

  // Address decode relative to the base, so an unaligned base still works
  assign sr_off   = sr_bus_addr - SR_BASE;
  assign sr_hit   = (sr_off < RW'(4));
  assign wr_pend  = sr_bus_we && sr_hit && (sr_off[1:0] == IRQC_SR_PEND);
  assign wr_mask  = sr_bus_we && sr_hit && (sr_off[1:0] == IRQC_SR_MASK);
  assign wr_state = sr_bus_we && sr_hit && (sr_off[1:0] == IRQC_SR_STATE);

  assign masked    = pend_reg & mask_reg;
  assign exc_any   = i_exc_mem | i_exc_trap | i_exc_sys;
  assign line_req  = (state_reg == IRQC_ST_IDLE) && i_irq_en && (|masked);
  assign o_irq     = exc_any | line_req;
  assign take_line = i_take && !exc_any && line_req;
  assign o_cause   = cause_reg;

  // Bits that only some configurations consume
  assign unused_ok = &{1'b0, sr_bus_data_i, irq_rise, irq_s};

  // Lowest-numbered masked pending line wins
  always_comb begin
    win_idx = '0;
    for (int k = N_IRQ - 1; k >= 0; k--) begin
      if (masked[k]) win_idx = IW'(k);
    end
  end

  // Exception priority: mem over trap over sys
  always_comb begin
    exc_code = IRQC_EXC_SYS;
    if (i_exc_mem)       exc_code = IRQC_EXC_MEM;
    else if (i_exc_trap) exc_code = IRQC_EXC_TRAP;
  end

  // Pending bits: edge lines set on a rising edge and clear on take or W1C,
  // with a same-cycle edge winning; level lines follow the synchronised input
  generate
    for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_pend
      if (EDGE_MASK[gi]) begin : g_edge
        logic clr;
        assign clr = (take_line && (win_idx == IW'(gi))) || (wr_pend && sr_bus_data_i[gi]);
        assign pend_next[gi] = irq_rise[gi] | (pend_reg[gi] & ~clr);
      end else begin : g_level
        assign pend_next[gi] = irq_s[gi];
      end
    end
  endgenerate

  // Cause latches only when something is actually taken; exceptions beat lines
  always_comb begin
    cause_next = cause_reg;
    if (i_take && exc_any) begin
      cause_next                = '0;
      cause_next[CAUSE_EXC_BIT] = 1'b1;
      cause_next[3:0]           = exc_code;
    end else if (take_line) begin
      cause_next = RW'(win_idx);
    end
  end

  // Take has priority over return and over a software write forcing IDLE
  always_comb begin
    state_next = state_reg;
    if (i_take)                              state_next = IRQC_ST_SERVICE;
    else if (i_irt)                          state_next = IRQC_ST_IDLE;
    else if (wr_state && !sr_bus_data_i[0])  state_next = IRQC_ST_IDLE;
  end

  // SR-bus read mux, zero outside the four-register window
  always_comb begin
    sr_bus_data_o = '0;
    if (sr_hit) begin
      case (sr_off[1:0])
        IRQC_SR_PEND:  sr_bus_data_o = RW'(pend_reg);
        IRQC_SR_MASK:  sr_bus_data_o = RW'(mask_reg);
        IRQC_SR_CAUSE: sr_bus_data_o = cause_reg;
        default:       sr_bus_data_o = RW'(state_reg == IRQC_ST_SERVICE);
      endcase
    end
  end

  // Controller registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= IRQC_ST_IDLE;
      pend_reg  <= '0;
      mask_reg  <= '0;
      cause_reg <= '0;
    end else begin
      state_reg <= state_next;
      pend_reg  <= pend_next;
      cause_reg <= cause_next;
      if (wr_mask) mask_reg <= sr_bus_data_i[N_IRQ-1:0];
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed-vector bench for irq_ctrl: line latching, masking, priority,
// exceptions, SR-bus access, state transitions and reset.
module tb_irq_ctrl;

  localparam int          RW          = 16;
  localparam int          N_IRQ       = 8;
  localparam int          SYNC_STAGES = 2;
  localparam logic [7:0]  EDGE_MASK   = 8'h3E;    // lines 1..5 edge, others level
  localparam logic [15:0] SR_BASE     = 16'h0200;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [7:0]  i_irq = '0;
  logic        i_irq_en = 1'b0, i_exc_sys = 1'b0, i_exc_trap = 1'b0, i_exc_mem = 1'b0;
  logic        i_take = 1'b0, i_irt = 1'b0;
  logic        o_irq;
  logic [15:0] o_cause;
  logic [15:0] sr_bus_addr = '0, sr_bus_data_i = '0, sr_bus_data_o;
  logic        sr_bus_we = 1'b0;

  int vec_cnt = 0;
  int err_cnt = 0;

  irq_ctrl #(
    .RW(RW), .N_IRQ(N_IRQ), .SYNC_STAGES(SYNC_STAGES),
    .EDGE_MASK(EDGE_MASK), .SR_BASE(SR_BASE)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_irq(i_irq), .i_irq_en(i_irq_en),
    .i_exc_sys(i_exc_sys), .i_exc_trap(i_exc_trap), .i_exc_mem(i_exc_mem),
    .i_take(i_take), .i_irt(i_irt), .o_irq(o_irq), .o_cause(o_cause),
    .sr_bus_addr(sr_bus_addr), .sr_bus_data_i(sr_bus_data_i),
    .sr_bus_we(sr_bus_we), .sr_bus_data_o(sr_bus_data_o)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected finish earlier");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %-14s got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %-14s %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] off, input logic [15:0] exp);
    sr_bus_addr = SR_BASE + 16'(off);
    #1;
    check(tag, 32'(sr_bus_data_o), 32'(exp));
    sr_bus_addr = '0;
  endtask

  task automatic sr_wr(input logic [1:0] off, input logic [15:0] data);
    sr_bus_addr   = SR_BASE + 16'(off);
    sr_bus_data_i = data;
    sr_bus_we     = 1'b1;
    step();
    sr_bus_we     = 1'b0;
    sr_bus_addr   = '0;
    sr_bus_data_i = '0;
  endtask

  // One-cycle pulse on the given lines, then wait until it is latched
  task automatic pulse(input logic [7:0] lines);
    i_irq = i_irq | lines;
    step();
    i_irq = i_irq & ~lines;
    step();
    step();
  endtask

  task automatic take();
    i_take = 1'b1;
    step();
    i_take = 1'b0;
  endtask

  task automatic irt();
    i_irt = 1'b1;
    step();
    i_irt = 1'b0;
  endtask

  initial begin
    // Reset values
    repeat (3) step();
    i_rst = 1'b0;
    check("rst_oirq", 32'(o_irq), 32'd0);
    chk_reg("rst_pend",  2'd0, 16'h0000);
    chk_reg("rst_mask",  2'd1, 16'h0000);
    chk_reg("rst_cause", 2'd2, 16'h0000);
    chk_reg("rst_state", 2'd3, 16'h0000);
    sr_bus_addr = SR_BASE + 16'd4;
    #1;
    check("oor_read", 32'(sr_bus_data_o), 32'd0);
    sr_bus_addr = '0;

    // Mask width: upper bits read as zero; cause is read-only
    sr_wr(2'd1, 16'hFFFF);
    chk_reg("mask_zext", 2'd1, 16'h00FF);
    sr_wr(2'd2, 16'h1234);
    chk_reg("cause_ro", 2'd2, 16'h0000);

    // Edge line 3, single-cycle pulse
    sr_wr(2'd1, 16'h0008);
    i_irq_en = 1'b1;
    i_irq    = 8'h08;
    step();
    i_irq    = 8'h00;
    step();
    check("l3_early", 32'(o_irq), 32'd0);
    step();
    check("l3_oirq", 32'(o_irq), 32'd1);
    chk_reg("l3_pend", 2'd0, 16'h0008);
    take();
    chk_reg("l3_cause", 2'd2, 16'h0003);
    chk_reg("l3_pendclr", 2'd0, 16'h0000);
    chk_reg("l3_state", 2'd3, 16'h0001);
    check("l3_cause_o", 32'(o_cause), 32'h0003);
    irt();
    chk_reg("l3_idle", 2'd3, 16'h0000);

    // Lines 2 and 5 pending: lowest wins, then the other after return
    sr_wr(2'd1, 16'h00FF);
    pulse(8'h24);
    chk_reg("p25_pend", 2'd0, 16'h0024);
    take();
    chk_reg("p25_cause2", 2'd2, 16'h0002);
    chk_reg("p25_pend5", 2'd0, 16'h0020);
    check("p25_svc_blk", 32'(o_irq), 32'd0);
    irt();
    check("p25_oirq", 32'(o_irq), 32'd1);
    take();
    chk_reg("p25_cause5", 2'd2, 16'h0005);
    chk_reg("p25_pend0", 2'd0, 16'h0000);
    irt();

    // Level line 0: W1C has no effect, clears SYNC_STAGES+1 cycles after low
    i_irq[0] = 1'b1;
    repeat (SYNC_STAGES + 1) step();
    chk_reg("lvl_pend", 2'd0, 16'h0001);
    sr_wr(2'd0, 16'h0001);
    chk_reg("lvl_w1c", 2'd0, 16'h0001);
    i_irq[0] = 1'b0;
    repeat (SYNC_STAGES) step();
    chk_reg("lvl_still", 2'd0, 16'h0001);
    step();
    chk_reg("lvl_low", 2'd0, 16'h0000);

    // Edge W1C clears an edge bit
    pulse(8'h10);
    chk_reg("w1c_set", 2'd0, 16'h0010);
    sr_wr(2'd0, 16'h0010);
    chk_reg("w1c_clr", 2'd0, 16'h0000);

    // Take with no request: cause unchanged, still enters SERVICE
    check("nreq_oirq", 32'(o_irq), 32'd0);
    take();
    chk_reg("nreq_state", 2'd3, 16'h0001);
    chk_reg("nreq_cause", 2'd2, 16'h0005);

    // In SERVICE: line 1 blocked, mem exception goes through
    pulse(8'h02);
    check("svc_blk", 32'(o_irq), 32'd0);
    i_exc_mem = 1'b1;
    #1;
    check("svc_exc", 32'(o_irq), 32'd1);
    take();
    i_exc_mem = 1'b0;
    #1;
    chk_reg("mem_cause", 2'd2, 16'h8002);
    chk_reg("mem_pend", 2'd0, 16'h0002);
    check("mem_blk", 32'(o_irq), 32'd0);
    irt();
    check("l1_oirq", 32'(o_irq), 32'd1);
    take();
    chk_reg("l1_cause", 2'd2, 16'h0001);
    irt();

    // Exceptions ignore enable and mask; priority mem > trap > sys
    i_irq_en = 1'b0;
    sr_wr(2'd1, 16'h0000);
    i_exc_sys = 1'b1;
    #1;
    check("sys_oirq", 32'(o_irq), 32'd1);
    take();
    chk_reg("sys_cause", 2'd2, 16'h8000);
    i_exc_mem = 1'b1; i_exc_trap = 1'b1;
    take();
    chk_reg("all_cause", 2'd2, 16'h8002);
    i_exc_mem = 1'b0;
    take();
    chk_reg("trap_cause", 2'd2, 16'h8001);
    i_exc_trap = 1'b0; i_exc_sys = 1'b0;
    irt();

    // Disabled: a masked-in pending line does not request
    sr_wr(2'd1, 16'h00FF);
    pulse(8'h04);
    chk_reg("dis_pend", 2'd0, 16'h0004);
    check("dis_oirq", 32'(o_irq), 32'd0);

    // take+irt together -> SERVICE; state write 0 forces IDLE
    i_take = 1'b1; i_irt = 1'b1;
    step();
    i_take = 1'b0; i_irt = 1'b0;
    chk_reg("tkirt_state", 2'd3, 16'h0001);
    sr_wr(2'd3, 16'h0000);
    chk_reg("wr_idle", 2'd3, 16'h0000);

    // Reset during SERVICE
    take();
    chk_reg("pre_rst_st", 2'd3, 16'h0001);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    check("rst2_oirq", 32'(o_irq), 32'd0);
    chk_reg("rst2_pend",  2'd0, 16'h0000);
    chk_reg("rst2_mask",  2'd1, 16'h0000);
    chk_reg("rst2_cause", 2'd2, 16'h0000);
    chk_reg("rst2_state", 2'd3, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
